// File: rtl/aftab_div_sequencer_pkg.sv
// Shared AAU definitions for the divide sequencer: default operand width
// and the sequencer state encoding.
package aftab_div_sequencer_pkg;

  localparam int AAU_LEN = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } divState_t;

endpackage

// File: rtl/aftab_twos_complementer.sv
// Conditional two's-complement negate. Used both to turn signed operands into
// magnitudes and to restore the sign of the unsigned divider result.
module aftab_twos_complementer #(
  parameter int len = 32
) (
  input  logic           negate,
  input  logic [len-1:0] a,
  output logic [len-1:0] y
);

  assign y = negate ? (~a + len'(1)) : a;

endmodule

// File: rtl/aftab_div_sequencer.sv
// Divide sequencer between the AAU and an unsigned (len+1)-bit divider.
// Converts signed operands to magnitudes, short-circuits divide-by-zero and
// signed overflow, launches the divider, and sign-corrects the selected result.
module aftab_div_sequencer
  import aftab_div_sequencer_pkg::*;
#(
  parameter int len = AAU_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           startDivAAU,
  input  logic [len-1:0] dividend,
  input  logic [len-1:0] divisor,
  input  logic           signedOp,
  input  logic           selRem,
  input  logic           doneDiv,
  input  logic [len:0]   quotientIn,
  input  logic [len:0]   remainderIn,
  output logic           startDiv,
  output logic [len:0]   dividendMag,
  output logic [len:0]   divisorMag,
  output logic [len-1:0] divResult,
  output logic           doneDivAAU,
  output logic           busy,
  output logic           dvByZero
);

  localparam logic [len-1:0] MIN_NEG = {1'b1, {(len-1){1'b0}}};

  divState_t state, nextState;

  logic           accept, capture, fixStage;
  logic           reqDivZero, reqOvf;
  logic [len-1:0] dividendAbs, divisorAbs;

  logic [len-1:0] dividendReg;
  logic           divisorNegReg, signedReg, selRemReg, divZeroReg, ovfReg;
  logic [len-1:0] quoCap, remCap;

  logic [len-1:0] resSel, resCorr, fixValue;
  logic           negResult;

  // The divider only ever produces len-bit results here; its extra top bit is dropped.
  logic unusedTopBits;
  assign unusedTopBits = quotientIn[len] ^ remainderIn[len];

  assign reqDivZero = (divisor == '0);
  assign reqOvf     = signedOp && (dividend == MIN_NEG) && (divisor == '1);

  aftab_twos_complementer #(.len(len)) uDividendAbs (
    .negate (signedOp & dividend[len-1]),
    .a      (dividend),
    .y      (dividendAbs)
  );

  aftab_twos_complementer #(.len(len)) uDivisorAbs (
    .negate (signedOp & divisor[len-1]),
    .a      (divisor),
    .y      (divisorAbs)
  );

  assign resSel    = selRemReg ? remCap : quoCap;
  assign negResult = signedReg &
                     (selRemReg ? dividendReg[len-1] : (dividendReg[len-1] ^ divisorNegReg));

  aftab_twos_complementer #(.len(len)) uResultFix (
    .negate (negResult),
    .a      (resSel),
    .y      (resCorr)
  );

  // Final value: special cases bypass the divider result entirely.
  always_comb begin
    fixValue = resCorr;
    if (divZeroReg) begin
      fixValue = selRemReg ? dividendReg : '1;
    end else if (ovfReg) begin
      fixValue = selRemReg ? '0 : MIN_NEG;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and Moore/handshake outputs.
  always_comb begin
    nextState  = state;
    startDiv   = 1'b0;
    doneDivAAU = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    fixStage   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (startDivAAU) begin
          accept    = 1'b1;
          nextState = (reqDivZero || reqOvf) ? FIX : LAUNCH;
        end
      end
      LAUNCH: begin
        startDiv  = 1'b1;
        nextState = WAIT;
      end
      WAIT: begin
        if (doneDiv) begin
          capture   = 1'b1;
          nextState = FIX;
        end
      end
      FIX: begin
        fixStage  = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        doneDivAAU = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, divider result capture and final result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividendReg   <= '0;
      divisorNegReg <= 1'b0;
      signedReg     <= 1'b0;
      selRemReg     <= 1'b0;
      divZeroReg    <= 1'b0;
      ovfReg        <= 1'b0;
      dividendMag   <= '0;
      divisorMag    <= '0;
      quoCap        <= '0;
      remCap        <= '0;
      divResult     <= '0;
      dvByZero      <= 1'b0;
    end else begin
      if (accept) begin
        dividendReg   <= dividend;
        divisorNegReg <= divisor[len-1];
        signedReg     <= signedOp;
        selRemReg     <= selRem;
        divZeroReg    <= reqDivZero;
        ovfReg        <= reqOvf;
        dividendMag   <= {1'b0, dividendAbs};
        divisorMag    <= {1'b0, divisorAbs};
      end
      if (capture) begin
        quoCap <= quotientIn[len-1:0];
        remCap <= remainderIn[len-1:0];
      end
      if (fixStage) begin
        divResult <= fixValue;
        dvByZero  <= divZeroReg;
      end
    end
  end

endmodule

// File: doc/aftab_div_sequencer.md
AFTAB_DIV_SEQUENCER -- requirements
Module: aftab_div_sequencer

Interface
REQ-001 The block SHALL be clocked by one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter: len, 32, operand/result width; the downstream divider datapath SHALL be len+1 bits wide.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 startDivAAU  input  1  request from AAU; sampled only in IDLE.
REQ-006 dividend, divisor  input  len each  raw operands, sampled with startDivAAU.
REQ-007 signedOp  input  1  1 = DIV/REM, 0 = DIVU/REMU; sampled with startDivAAU.
REQ-008 selRem  input  1  1 = return remainder, 0 = quotient; sampled with startDivAAU.
REQ-009 doneDiv  input  1  completion pulse from divider controller.
REQ-010 quotientIn, remainderIn  input  len+1 each  unsigned divider results.
REQ-011 startDiv  output  1  one-cycle launch pulse to divider controller.
REQ-012 dividendMag, divisorMag  output  len+1 each  zero-extended operand magnitudes to divider.
REQ-013 divResult  output  len  final sign-corrected result, held until next accepted request.
REQ-014 doneDivAAU  output  1  one-cycle completion pulse to AAU.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 dvByZero  output  1  registered flag, valid with doneDivAAU, held with divResult.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, FIX, DONE.
REQ-018 IDLE: on startDivAAU=1, register operands, signedOp, selRem; next state FIX if divisor=0 or (signedOp and dividend=0x80000000 and divisor=all-ones), else LAUNCH.
REQ-019 Operand magnitude: if signedOp and operand MSB=1, two's-complement negate; result zero-extended to len+1 (0x80000000 -> 0x080000000).
REQ-020 LAUNCH: startDiv=1 for exactly one cycle with dividendMag/divisorMag stable; next state WAIT.
REQ-021 dividendMag/divisorMag SHALL stay stable from LAUNCH until doneDiv is accepted.
REQ-022 WAIT: on doneDiv=1, capture quotientIn[len-1:0] and remainderIn[len-1:0]; next state FIX; otherwise stay.
REQ-023 doneDiv outside WAIT SHALL be ignored; startDivAAU outside IDLE SHALL be ignored.
REQ-024 FIX, normal: quotient negated iff signedOp and dividend MSB xor divisor MSB; remainder negated iff signedOp and dividend MSB; selected value registered into divResult; next DONE.
REQ-025 FIX, divisor=0: quotient=all-ones (both signed/unsigned), remainder=dividend; dvByZero=1.
REQ-026 FIX, signed overflow: quotient=0x80000000, remainder=0; dvByZero=0.
REQ-027 DONE: doneDivAAU=1 for one cycle; next IDLE; a new request is accepted in the following IDLE cycle at the earliest.
REQ-028 Latency startDivAAU->doneDivAAU: special cases 3 cycles; normal = 4 + cycles from startDiv to doneDiv.
REQ-029 dvByZero SHALL clear when a non-zero-divisor request reaches FIX.

Reset
REQ-030 rst SHALL force IDLE and clear divResult, dividendMag, divisorMag, captured results, dvByZero; startDiv, doneDivAAU, busy SHALL be 0 in the cycle after rst.
REQ-031 rst mid-operation (any state) SHALL abandon the transfer with no doneDivAAU; a late doneDiv after reset SHALL be ignored.

Structure
REQ-032 State encodings and the len default SHALL live in a shared AAU package.
REQ-033 One sub-module, aftab_twos_complementer (conditional negate, len bits), SHALL be instantiated for operand and result correction.

Verification
REQ-034 signed 100/7, selRem=0 -> divResult=14; selRem=1 -> 2; doneDivAAU one cycle.
REQ-035 signed -100 (0xFFFFFF9C)/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
REQ-036 5/0 unsigned -> quotient 0xFFFFFFFF, remainder 5, dvByZero=1, startDiv never asserted, 3-cycle latency.
REQ-037 signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, no startDiv.
REQ-038 unsigned 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1; startDivAAU re-pulsed in WAIT ignored.
REQ-039 rst asserted in WAIT, doneDiv pulsed next cycle -> IDLE, no doneDivAAU, divResult=0.
